// File: rtl/save_state_responder_pkg.sv
// Shared save-state definitions: bus address width, the per-unit address map
// and the responder FSM state type.
`ifndef SAVE_STATE_BITS
`define SAVE_STATE_BITS 8
`endif
`ifndef SAVE_STATE_LAST_ADDRESS
`define SAVE_STATE_LAST_ADDRESS 255
`endif

package save_state_responder_pkg;

    localparam int SAVE_STATE_BITS         = `SAVE_STATE_BITS;
    localparam int SAVE_STATE_LAST_ADDRESS = `SAVE_STATE_LAST_ADDRESS;

    // Address map: every responder instance takes its window from here so
    // that no two windows overlap on the OR-combined read-data bus.
    localparam int PPU_BASE_ADDR    = 0;
    localparam int PPU_NUM_WORDS    = 24;
    localparam int APU_BASE_ADDR    = PPU_BASE_ADDR + PPU_NUM_WORDS;
    localparam int APU_NUM_WORDS    = 16;
    localparam int MAPPER_BASE_ADDR = APU_BASE_ADDR + APU_NUM_WORDS;
    localparam int MAPPER_NUM_WORDS = 8;

    typedef enum logic [1:0] {
        SS_IDLE    = 2'd0,
        SS_SAVING  = 2'd1,
        SS_LOADING = 2'd2,
        SS_COMMIT  = 2'd3
    } save_state_t;

    // Word-offset width inside a window; a one-word window still needs one bit.
    function automatic int off_width(input int num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

endpackage

// File: rtl/save_state_responder_if.sv
// Save-state bus between the controller (master) and each responder (slave).
//   begin_save_state / begin_load_state : operation strobes
//   state_addr                          : word address
//   state_read_en / state_write_en      : access strobes
//   state_write_data                    : write data
//   state_read_data                     : registered read data, zero when not selected
interface save_state_responder_if;
    import save_state_responder_pkg::*;

    logic                       begin_save_state;
    logic                       begin_load_state;
    logic [SAVE_STATE_BITS-1:0] state_addr;
    logic                       state_read_en;
    logic                       state_write_en;
    logic [15:0]                state_write_data;
    logic [15:0]                state_read_data;

    modport master (
        output begin_save_state, begin_load_state, state_addr,
               state_read_en, state_write_en, state_write_data,
        input  state_read_data
    );

    modport slave (
        input  begin_save_state, begin_load_state, state_addr,
               state_read_en, state_write_en, state_write_data,
        output state_read_data
    );
endinterface

// File: rtl/save_state_shadow_bank.sv
// Shadow register bank: NUM_WORDS x 16 bits.
//   clock, reset             : clock, async active-high reset (bank cleared)
//   capture_en/capture_data  : parallel load of the whole bank
//   wr_en/wr_off/wr_data     : single word write
//   rd_en/rd_off/rd_data     : registered read, zero when rd_en is low
//   bank                     : current contents, word k at [16k+15:16k]
module save_state_shadow_bank #(
    parameter int NUM_WORDS = 4,
    parameter int OFF_W     = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   capture_en,
    input  logic [16*NUM_WORDS-1:0] capture_data,
    input  logic                   wr_en,
    input  logic [OFF_W-1:0]       wr_off,
    input  logic [15:0]            wr_data,
    input  logic                   rd_en,
    input  logic [OFF_W-1:0]       rd_off,
    output logic [15:0]            rd_data,
    output logic [16*NUM_WORDS-1:0] bank
);

    // The read samples the bank before this edge's write, so a read and a
    // write to the same word in one cycle return the old word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bank    <= '0;
            rd_data <= '0;
        end else begin
            if (capture_en) begin
                bank <= capture_data;
            end else if (wr_en) begin
                bank[16*int'(wr_off) +: 16] <= wr_data;
            end
            rd_data <= rd_en ? bank[16*int'(rd_off) +: 16] : 16'h0000;
        end
    end

endmodule

// File: rtl/save_state_responder.sv
// Save-state target endpoint for one unit.
//   clock, reset    : clock, async active-high reset
//   bus             : save-state bus (slave side)
//   live_data       : unit's live registers, word k at [16k+15:16k]
//   restore_data    : shadow bank contents, same packing
//   restore_valid   : one-cycle pulse telling the unit to load restore_data
//   busy            : high while saving, loading or committing
//
// state      | meaning
// SS_IDLE    | waiting for begin_save_state / begin_load_state
// SS_SAVING  | bank holds the snapshot; controller reads words out
// SS_LOADING | controller writes words into the bank
// SS_COMMIT  | restore_valid high for this single cycle
module save_state_responder
    import save_state_responder_pkg::*;
#(
    parameter int BASE_ADDR = 0,
    parameter int NUM_WORDS = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    save_state_responder_if.slave   bus,
    input  logic [16*NUM_WORDS-1:0] live_data,
    output logic [16*NUM_WORDS-1:0] restore_data,
    output logic                    restore_valid,
    output logic                    busy
);

    localparam int OFF_W = off_width(NUM_WORDS);
    localparam int AW    = SAVE_STATE_BITS + 1;

    // One extra bit so BASE_ADDR+NUM_WORDS at the top of the map cannot wrap.
    localparam logic [AW-1:0]    WIN_LO   = AW'(BASE_ADDR);
    localparam logic [AW-1:0]    WIN_HI   = AW'(BASE_ADDR + NUM_WORDS);
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(NUM_WORDS - 1);

    logic [AW-1:0]    addr_ext;
    logic             hit;
    logic [OFF_W-1:0] off;
    logic             capture_en;
    logic             wr_en;
    logic             rd_en;
    save_state_t      state;

    assign addr_ext = {1'b0, bus.state_addr};
    assign hit      = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
    assign off      = OFF_W'(addr_ext - WIN_LO);

    assign capture_en = (state == SS_IDLE) && bus.begin_save_state;
    assign wr_en      = (state == SS_LOADING) && bus.state_write_en && hit;
    assign rd_en      = bus.state_read_en && hit;

    save_state_shadow_bank #(
        .NUM_WORDS (NUM_WORDS),
        .OFF_W     (OFF_W)
    ) u_bank (
        .clock        (clock),
        .reset        (reset),
        .capture_en   (capture_en),
        .capture_data (live_data),
        .wr_en        (wr_en),
        .wr_off       (off),
        .wr_data      (bus.state_write_data),
        .rd_en        (rd_en),
        .rd_off       (off),
        .rd_data      (bus.state_read_data),
        .bank         (restore_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= SS_IDLE;
            restore_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            restore_valid <= 1'b0;
            case (state)
                SS_IDLE: begin
                    if (bus.begin_save_state) begin
                        state <= SS_SAVING;
                        busy  <= 1'b1;
                    end else if (bus.begin_load_state) begin
                        state <= SS_LOADING;
                        busy  <= 1'b1;
                    end
                end
                SS_SAVING: begin
                    if (rd_en && (off == LAST_OFF)) begin
                        state <= SS_IDLE;
                        busy  <= 1'b0;
                    end
                end
                SS_LOADING: begin
                    if (wr_en && (off == LAST_OFF)) begin
                        state         <= SS_COMMIT;
                        restore_valid <= 1'b1;
                    end
                end
                SS_COMMIT: begin
                    state <= SS_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= SS_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_save_state_responder.sv
// Scoreboard bench for save_state_responder (BASE_ADDR=4, NUM_WORDS=3).
module tb_save_state_responder;
    import save_state_responder_pkg::*;

    localparam int BASE = 4;
    localparam int NW   = 3;
    localparam int DW   = 16*NW;

    localparam int K_RD = 0, K_RV = 1, K_BUSY = 2, K_RDATA = 3;
    localparam int M_IDLE = 0, M_SAVE = 1, M_LOAD = 2, M_COMMIT = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] live_data;
    logic [DW-1:0] restore_data;
    logic          restore_valid;
    logic          busy;

    always #5 clock = ~clock;

    save_state_responder_if bus ();

    save_state_responder #(
        .BASE_ADDR (BASE),
        .NUM_WORDS (NW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus),
        .live_data     (live_data),
        .restore_data  (restore_data),
        .restore_valid (restore_valid),
        .busy          (busy)
    );

    typedef struct {
        int            due;
        int            kind;
        logic [DW-1:0] val;
        string         name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // reference model: operating mode and shadow words
    int          m_mode = M_IDLE;
    logic [15:0] m_sh[NW];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // monitor: every output has an expectation queued for each cycle
    always @(negedge clock) begin
        exp_t          e;
        logic [DW-1:0] act;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
                K_RD:    act = DW'(bus.state_read_data);
                K_RV:    act = DW'(restore_valid);
                K_BUSY:  act = DW'(busy);
                default: act = restore_data;
            endcase
            if (e.due != cyc) begin
                checks++;
                failures++;
                $display("FAIL %s stale expectation: due %0d now %0d", e.name, e.due, cyc);
            end else begin
                check(e.name, act, e.val);
            end
        end
    end

    task automatic model_reset();
        m_mode = M_IDLE;
        for (int k = 0; k < NW; k++) m_sh[k] = 16'h0000;
    endtask

    // Drive one cycle, advance the model, queue the outputs expected after the edge.
    task automatic step(input string nm, input logic bs, input logic bl, input int addr,
                        input logic re, input logic we, input logic [15:0] wd);
        logic [15:0]   exp_rd;
        logic [DW-1:0] packed_sh;
        bit            h;
        int            o;
        bus.begin_save_state = bs;
        bus.begin_load_state = bl;
        bus.state_addr       = SAVE_STATE_BITS'(addr);
        bus.state_read_en    = re;
        bus.state_write_en   = we;
        bus.state_write_data = wd;
        h = (addr >= BASE) && (addr < BASE + NW);
        o = addr - BASE;
        exp_rd = (re && h) ? m_sh[o] : 16'h0000;
        case (m_mode)
            M_IDLE: begin
                if (bs) begin
                    for (int k = 0; k < NW; k++) m_sh[k] = live_data[16*k +: 16];
                    m_mode = M_SAVE;
                end else if (bl) begin
                    m_mode = M_LOAD;
                end
            end
            M_SAVE:  if (re && h && o == NW-1) m_mode = M_IDLE;
            M_LOAD: begin
                if (we && h) begin
                    m_sh[o] = wd;
                    if (o == NW-1) m_mode = M_COMMIT;
                end
            end
            default: m_mode = M_IDLE;
        endcase
        for (int k = 0; k < NW; k++) packed_sh[16*k +: 16] = m_sh[k];
        sb.push_back('{cyc+1, K_RD,    DW'(exp_rd),              {nm, ".rd"}});
        sb.push_back('{cyc+1, K_RV,    DW'(m_mode == M_COMMIT),  {nm, ".restore_valid"}});
        sb.push_back('{cyc+1, K_BUSY,  DW'(m_mode != M_IDLE),    {nm, ".busy"}});
        sb.push_back('{cyc+1, K_RDATA, packed_sh,                {nm, ".restore_data"}});
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input string nm);
        step(nm, 1'b0, 1'b0, 0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic rd(input string nm, input int addr);
        step(nm, 1'b0, 1'b0, addr, 1'b1, 1'b0, 16'h0000);
    endtask

    task automatic wr(input string nm, input int addr, input logic [15:0] wd);
        step(nm, 1'b0, 1'b0, addr, 1'b0, 1'b1, wd);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, ".rd"},            DW'(bus.state_read_data), '0);
        check({nm, ".restore_data"},  restore_data,             '0);
        check({nm, ".restore_valid"}, DW'(restore_valid),       '0);
        check({nm, ".busy"},          DW'(busy),                '0);
    endtask

    task automatic apply_reset(input string nm);
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs(nm);
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.begin_save_state = 1'b0;
        bus.begin_load_state = 1'b0;
        bus.state_addr       = '0;
        bus.state_read_en    = 1'b0;
        bus.state_write_en   = 1'b0;
        bus.state_write_data = '0;
        live_data            = '0;
        model_reset();
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // save, then live data changes: reads still see the snapshot
        live_data = {16'h3333, 16'h2222, 16'h1111};
        step("save_go", 1'b1, 1'b0, 0, 1'b0, 1'b0, 16'h0);
        live_data = {16'h9999, 16'h8888, 16'h7777};
        rd("save_rd4", 4);
        rd("save_rd5", 5);
        rd("save_rd6", 6);
        idle("save_done");

        // window misses, one-cycle read data, ignored write and load strobe
        live_data = {16'h6666, 16'h5555, 16'h4444};
        step("save2_go", 1'b1, 1'b0, 0, 1'b0, 1'b0, 16'h0);
        live_data = {16'h0f0f, 16'h0e0e, 16'h0d0d};
        rd("miss_rd3", 3);
        rd("miss_rd7", 7);
        rd("hold_rd4", 4);
        idle("hold_gap");
        wr("save_wr_ignored", 4, 16'hdead);
        step("save_load_ignored", 1'b0, 1'b1, 0, 1'b0, 1'b0, 16'h0);
        rd("save2_rd4", 4);
        rd("save2_rd5", 5);
        rd("save2_rd6", 6);
        idle("save2_done");

        // load and commit
        step("load_go", 1'b0, 1'b1, 0, 1'b0, 1'b0, 16'h0);
        wr("load_wr4", 4, 16'haaaa);
        wr("load_wr5", 5, 16'hbbbb);
        wr("load_wr6", 6, 16'hcccc);
        // begin in the commit cycle is ignored; the next one is honoured
        live_data = {16'h1003, 16'h1002, 16'h1001};
        step("commit_bs_ignored", 1'b1, 1'b0, 0, 1'b0, 1'b0, 16'h0);
        step("b2b_save", 1'b1, 1'b0, 0, 1'b0, 1'b0, 16'h0);
        rd("b2b_rd4", 4);
        rd("b2b_rd5", 5);
        rd("b2b_rd6", 6);

        // both strobes together: save wins
        live_data = {16'h2003, 16'h2002, 16'h2001};
        step("both_go", 1'b1, 1'b1, 0, 1'b0, 1'b0, 16'h0);
        rd("both_rd6", 6);
        idle("both_done");

        // load with simultaneous read: read returns the old word
        step("rw_load_go", 1'b0, 1'b1, 0, 1'b0, 1'b0, 16'h0);
        step("rw_wr4", 1'b0, 1'b0, 4, 1'b1, 1'b1, 16'h4004);
        step("rw_wr5", 1'b0, 1'b0, 5, 1'b1, 1'b1, 16'h5005);
        rd("load_dbg_rd4", 4);
        step("rw_wr6", 1'b0, 1'b0, 6, 1'b1, 1'b1, 16'h6006);
        rd("commit_dbg_rd5", 5);
        rd("idle_dbg_rd6", 6);
        idle("rw_done");

        // reset in the middle of a load
        step("rst_load_go", 1'b0, 1'b1, 0, 1'b0, 1'b0, 16'h0);
        wr("rst_wr4", 4, 16'h1234);
        wr("rst_wr5", 5, 16'h5678);
        apply_reset("mid_load_reset");
        idle("post_reset_idle");
        live_data = {16'hc0c3, 16'hc0c2, 16'hc0c1};
        step("fresh_save", 1'b1, 1'b0, 0, 1'b0, 1'b0, 16'h0);
        rd("fresh_rd4", 4);
        rd("fresh_rd5", 5);
        rd("fresh_rd6", 6);
        idle("fresh_done");

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0)
                live_data = {$urandom_range(0, 65535), $urandom_range(0, 65535),
                             $urandom_range(0, 65535)};
            step("rand",
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 7) == 0),
                 int'($urandom_range(2, 8)),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 1) == 1),
                 16'($urandom_range(0, 65535)));
        end
        idle("drain0");
        idle("drain1");
        @(negedge clock);
        #1;
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/save_state_responder.md
# save_state_responder

Target-side endpoint of the save-state bus: one instance sits in each unit (PPU, APU, mappers) whose registers must be snapshotted. On a save it captures the unit's live registers atomically into a shadow bank, then serves the controller's sequential word reads. On a load it accepts the controller's word writes into the shadow bank and, after the last word, pulses a one-cycle restore to the unit. Read data is zero outside the instance's address window, so all responders' outputs can be OR-combined onto the controller's read-data input.

## Interface
Parameters:
- BASE_ADDR, 0: first save-state word address owned by this instance.
- NUM_WORDS, 4: number of 16-bit words owned (1..64); window is BASE_ADDR..BASE_ADDR+NUM_WORDS-1.

Ports:
- clock  in  1  sole clock; everything is rising-edge.
- reset  in  1  asynchronous, active-high.
- begin_save_state  in  1  same strobe the controller sees.
- begin_load_state  in  1  same strobe the controller sees.
- state_addr  in  `SAVE_STATE_BITS  word address from the controller.
- state_read_en  in  1  read strobe.
- state_write_en  in  1  write strobe.
- state_write_data  in  16  write data, valid with state_write_en.
- state_read_data  out  16  registered read data; zero when not selected.
- live_data  in  16*NUM_WORDS  unit's current registers; word k is bits [16k+15:16k].
- restore_data  out  16*NUM_WORDS  shadow bank contents, same packing.
- restore_valid  out  1  one-cycle pulse: unit loads restore_data.
- busy  out  1  high in SAVING, LOADING and COMMIT.

## Operation
- hit = (state_addr >= BASE_ADDR) && (state_addr < BASE_ADDR+NUM_WORDS); compare at `SAVE_STATE_BITS+1 bits so no wrap.
- off = state_addr - BASE_ADDR, truncated to $clog2(NUM_WORDS) bits (minimum 1).
- FSM states:
  - IDLE: on begin_save_state, shadow <= live_data at that edge, go to SAVING. Otherwise, on begin_load_state, go to LOADING. If both are high, save wins.
  - SAVING: a read with hit returns shadow[off]. A read hit with off==NUM_WORDS-1 goes to IDLE.
  - LOADING: a write with hit sets shadow[off] <= state_write_data. A write hit with off==NUM_WORDS-1 writes the word and goes to COMMIT.
  - COMMIT: restore_valid=1 for exactly this cycle, then IDLE.
- begin_* strobes are ignored outside IDLE.
- Writes outside LOADING are ignored.
- Reads with hit in IDLE, LOADING or COMMIT still return shadow[off] (debug visibility). Reads without hit return 16'h0000.
- Simultaneous read_en and write_en: the read is served, and in LOADING the write is also applied. The read returns the old word.
- Reset, including mid-save or mid-load: go to IDLE, shadow cleared to 0, no restore_valid.

## Timing
- Reset values: state_read_data=0, restore_data=0, restore_valid=0, busy=0.
- Read latency is 1 cycle: address and read_en at edge N, data on state_read_data after edge N+1. This matches the controller, which captures read data one cycle after issuing the read.
- state_read_data returns to 0 the cycle after a cycle with no read hit; it is not held.
- Capture is on the same edge that begin_save_state is sampled; busy rises after that edge.
- Write latency: the shadow word updates on the edge where write_en is sampled. restore_data reflects it the next cycle.
- restore_valid rises one cycle after the edge that writes the last word. restore_data is stable while restore_valid is high.
- Back-to-back operations: a begin_* in the cycle after COMMIT or after the last SAVING read is honoured.

## Structure
- The shared save-state package/header holds:
  - `SAVE_STATE_BITS and `SAVE_STATE_LAST_ADDRESS;
  - the per-unit BASE_ADDR/NUM_WORDS constants, so the address map lives in one place;
  - the FSM state typedef (IDLE, SAVING, LOADING, COMMIT).
- Sub-module save_state_shadow_bank holds NUM_WORDS×16 registers, with:
  - parallel capture port;
  - single write port;
  - registered read port with zero-on-miss.
- The top level keeps the FSM, the hit/off decode and restore_valid.

## Test plan
Bench uses BASE_ADDR=4, NUM_WORDS=3.
- Save: live_data={16'h3333,16'h2222,16'h1111}, begin_save_state, then change live_data. Reads at 4,5,6 -> 16'h1111,16'h2222,16'h3333 one cycle after each read. FSM returns to IDLE after the addr-6 read.
- Window miss: reads at 3 and 7 during SAVING -> state_read_data 0. A read at 4 followed by an idle cycle -> data for one cycle, then 0.
- Load: begin_load_state, then writes 4<-AAAA, 5<-BBBB, 6<-CCCC. restore_valid pulses exactly once, one cycle after the addr-6 write. restore_data={CCCC,BBBB,AAAA}.
- Priority and ignores:
  - begin_save_state and begin_load_state together -> SAVING;
  - a write in SAVING leaves the shadow unchanged;
  - begin_load_state during SAVING is ignored.
- Reset mid-load: assert reset after the addr-5 write. Outputs go to 0 immediately (asynchronous), with no restore_valid; a fresh save then works.
